// File: rtl/iua_capture_ctrl.sv
// ---------------------------------------------------------------------------
// iua_capture_ctrl
// Capture controller sitting between an RLE compression core and a
// downstream 32-bit FIFO. It holds the core in reset while idle, packs the
// core's 1..4 byte output beats into 32-bit words, drains the core pipeline
// after a stop command, flushes any partial word, and stops early on a
// word limit or on FIFO overflow.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_start/cmd_stop  single-cycle command pulses
//   cfg_limit[15:0]     words per capture (0 = unlimited), latched on start
//   core_rst            reset to the RLE core (high while idle)
//   in_data/in_width/in_valid  core output beat, in_width+1 bytes, LSB first
//   fifo_data/fifo_we/fifo_full  FIFO write port
//   busy, overflow, word_count, done  status
// ---------------------------------------------------------------------------
module iua_capture_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic [15:0] cfg_limit,
  output logic        core_rst,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_width,
  input  logic        in_valid,
  output logic [31:0] fifo_data,
  output logic        fifo_we,
  input  logic        fifo_full,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] word_count,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, FINISH} stateT;

  stateT       r_state;
  logic        r_coreRst;
  logic        r_busy;
  logic        r_done;
  logic        r_overflow;
  logic        r_fifoWe;
  logic [31:0] r_fifoData;
  logic [15:0] r_wordCount;
  logic [15:0] r_limit;
  logic [1:0]  r_drainCnt;
  logic [23:0] r_resData;
  logic [1:0]  r_resCnt;

  stateT       w_nextState;
  logic        w_active;
  logic [31:0] w_newBytes;
  logic [55:0] w_combined;
  logic [2:0]  w_total;
  logic        w_packDue;
  logic        w_flushDue;
  logic        w_wordDue;
  logic [31:0] w_wordValue;
  logic        w_overflowEvt;
  logic        w_write;
  logic [15:0] w_countNext;
  logic        w_limitHit;

  // Packer datapath. New bytes above in_width are masked off so residual
  // upper bytes always stay zero, which lets the flush word be sent as-is.
  always_comb begin
    w_active = (r_state == RUN) || (r_state == DRAIN);
    case (in_width)
      2'd0:    w_newBytes = {24'h0, in_data[7:0]};
      2'd1:    w_newBytes = {16'h0, in_data[15:0]};
      2'd2:    w_newBytes = {8'h0, in_data[23:0]};
      default: w_newBytes = in_data;
    endcase
    w_combined  = ({24'h0, w_newBytes} << {r_resCnt, 3'b000}) | {32'h0, r_resData};
    w_total     = {1'b0, r_resCnt} + {1'b0, in_width} + 3'd1;
    w_packDue   = w_active && in_valid && w_total[2];
    w_flushDue  = (r_state == FLUSH) && (r_resCnt != 2'd0);
    w_wordDue   = w_packDue || w_flushDue;
    w_wordValue = w_flushDue ? {8'h00, r_resData} : w_combined[31:0];
    w_overflowEvt = w_wordDue && fifo_full;
    w_write     = w_wordDue && !fifo_full;
    w_countNext = (r_wordCount == 16'hFFFF) ? r_wordCount : r_wordCount + 16'd1;
    w_limitHit  = w_write && (r_limit != 16'd0) && (w_countNext == r_limit);
  end

  // Next-state decode. Limit and overflow take priority over cmd_stop.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:   if (cmd_start) w_nextState = RUN;
      RUN: begin
        if (w_overflowEvt || w_limitHit) w_nextState = FINISH;
        else if (cmd_stop)               w_nextState = DRAIN;
      end
      DRAIN: begin
        if (w_overflowEvt || w_limitHit) w_nextState = FINISH;
        else if (r_drainCnt == 2'd2)     w_nextState = FLUSH;
      end
      FLUSH:  w_nextState = FINISH;
      FINISH: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // All state and registered outputs. Status outputs are decoded from the
  // next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_coreRst   <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_fifoWe    <= 1'b0;
      r_fifoData  <= 32'h0;
      r_wordCount <= 16'h0;
      r_limit     <= 16'h0;
      r_drainCnt  <= 2'd0;
      r_resData   <= 24'h0;
      r_resCnt    <= 2'd0;
    end else begin
      r_state   <= w_nextState;
      r_busy    <= (w_nextState != IDLE);
      r_done    <= (w_nextState == FINISH);
      r_coreRst <= (w_nextState == IDLE);
      r_fifoWe  <= w_write;
      if (w_write) begin
        r_fifoData  <= w_wordValue;
        r_wordCount <= w_countNext;
      end
      if (w_overflowEvt) r_overflow <= 1'b1;
      r_drainCnt <= (r_state == DRAIN) ? r_drainCnt + 2'd1 : 2'd0;

      // Residual bytes: cleared on start and whenever a capture ends early
      // or flushes; otherwise the leftover after word extraction is kept.
      if ((r_state == IDLE) && cmd_start) begin
        r_overflow  <= 1'b0;
        r_wordCount <= 16'h0;
        r_limit     <= cfg_limit;
        r_resData   <= 24'h0;
        r_resCnt    <= 2'd0;
      end else if (w_overflowEvt || w_limitHit || (r_state == FLUSH)) begin
        r_resData <= 24'h0;
        r_resCnt  <= 2'd0;
      end else if (w_active && in_valid) begin
        r_resData <= w_total[2] ? w_combined[55:32] : w_combined[23:0];
        r_resCnt  <= w_total[1:0];
      end
    end
  end

  assign core_rst   = r_coreRst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign fifo_we    = r_fifoWe;
  assign fifo_data  = r_fifoData;
  assign word_count = r_wordCount;

endmodule

// File: doc/iua_capture_ctrl.md
IUA_CAPTURE_CTRL -- requirements
Module: iua_capture_ctrl

Interface
REQ-001 SHALL have: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: cmd_start  in  1  single-cycle pulse, begin capture.
REQ-004 SHALL have: cmd_stop  in  1  single-cycle pulse, end capture.
REQ-005 SHALL have: cfg_limit  in  16  word limit per capture, sampled on accepted cmd_start; 0 = unlimited.
REQ-006 SHALL have: core_rst  out  1  reset driven to the RLE core.
REQ-007 SHALL have: in_data  in  32, in_width  in  2, in_valid  in  1  RLE core output; byte count = in_width+1, first byte in_data[7:0], then ascending bytes.
REQ-008 SHALL have: fifo_data  out  32, fifo_we  out  1, fifo_full  in  1  downstream FIFO write port.
REQ-009 SHALL have: busy  out  1, overflow  out  1, word_count  out  16, done  out  1  status.

Function
REQ-010 SHALL implement states IDLE, RUN, DRAIN, FLUSH, FINISH.
REQ-011 IDLE: core_rst=1; cmd_start -> RUN, clears overflow, word_count and packer, latches cfg_limit.
REQ-012 RUN: core_rst=0; in_valid bytes packed; cmd_stop -> DRAIN.
REQ-013 DRAIN: core_rst=0 for exactly 3 cycles so the core pipeline empties; in_valid still packed; then -> FLUSH.
REQ-014 FLUSH: one cycle; if residual bytes 1..3, write one word with unused upper bytes = 8'h00; if 0 residual, no write; -> FINISH.
REQ-015 FINISH: one cycle, done=1, -> IDLE; done SHALL be 0 in all other states.
REQ-016 busy SHALL be 1 in RUN, DRAIN, FLUSH, FINISH; 0 in IDLE.
REQ-017 cmd_start outside IDLE and cmd_stop outside RUN SHALL be ignored; cmd_start and cmd_stop together in IDLE -> start wins.
REQ-018 in_valid in IDLE/FLUSH/FINISH SHALL be ignored.
REQ-019 Packer: residual 0..3 bytes plus up to 4 new; when total >= 4, lowest 4 bytes (oldest first, oldest in [7:0]) form a word; remainder 0..3 bytes retained; at most one word per cycle.
REQ-020 Word write registered: fifo_we=1 with fifo_data the cycle after the in_valid cycle completing it; fifo_we=0 otherwise.
REQ-021 word_count SHALL increment by 1 per fifo_we, saturating at 16'hFFFF.
REQ-022 Limit: when a write makes word_count equal latched cfg_limit (nonzero), -> FINISH next cycle; residual discarded, no flush.
REQ-023 Overflow: if a word is due while fifo_full=1, no write, word_count unchanged, overflow set sticky, -> FINISH next cycle, residual discarded.
REQ-024 Overflow and limit in the same cycle impossible (no write on overflow); cmd_stop in the same cycle as limit/overflow -> FINISH wins.
REQ-025 fifo_full SHALL be evaluated only in the cycle a word is due.

Reset
REQ-026 rst SHALL force IDLE, core_rst=1, fifo_we=0, fifo_data=0, done=0, busy=0, overflow=0, word_count=0, packer residual=0, latched limit=0, from any state, mid-capture included, with no flush write.

Verification
REQ-027 start, cfg_limit=0; four in_valid width=00 bytes 11,22,33,44; stop -> one write fifo_data=32'h44332211, word_count=1, done after DRAIN(3)+FLUSH+FINISH.
REQ-028 start; width=10 bytes AA,BB,CC then width=01 bytes DD,EE; stop -> writes 32'hDDCCBBAA then flush 32'h000000EE, word_count=2.
REQ-029 start, cfg_limit=2; eight width=11 words back-to-back -> exactly 2 writes, done, busy=0, later in_valid ignored.
REQ-030 fifo_full=1 when first word due -> fifo_we=0, overflow=1, word_count=0, done pulse; next cmd_start clears overflow.
REQ-031 rst asserted in DRAIN with 2 residual bytes -> no write, all outputs at reset values next cycle, core_rst=1.
REQ-032 cmd_start and cmd_stop same cycle in IDLE -> RUN, busy=1; cmd_start in RUN -> no effect, word_count preserved.
